// File: rtl/sumador_serial.sv
// Bit-serial unsigned adder with a start/busy/done handshake.
// A single full adder handles one operand bit per clock, LSB first, and the
// carry is kept in a register between cycles. The finished sum is registered
// and shown on two active-low 7-segment digits: the low hex nibble and the carry.
module sumador_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] Ent1,
    input  logic [WIDTH-1:0] Ent2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Resultado,
    output logic             Cout,
    output logic [6:0]       salida7seg0,
    output logic [6:0]       salida7seg1
);

    localparam int                IDX_W    = $clog2(WIDTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_ZERO = 7'b1000000;
    localparam logic [6:0] SEG_ONE  = 7'b1111001;

    typedef enum logic [1:0] {
        IDLE,
        SUMA,
        FIN
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_sh_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] resultado_q;
    logic             cout_q;

    logic             sum_bit;
    logic             carry_d;
    logic [WIDTH-1:0] sum_sh_d;
    logic [3:0]       nibble;

    // Full adder on the current LSBs; the new sum bit enters the sum register at the MSB
    always_comb begin
        sum_bit  = a_q[0] ^ b_q[0] ^ carry_q;
        carry_d  = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
        sum_sh_d = {sum_bit, sum_sh_q[WIDTH-1:1]};
    end

    // Control FSM and datapath: accept operands, add one bit per clock, publish the result
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_sh_q    <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            resultado_q <= '0;
            cout_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q      <= Ent1;
                        b_q      <= Ent2;
                        sum_sh_q <= '0;
                        carry_q  <= 1'b0;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= SUMA;
                    end
                end
                SUMA: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    carry_q  <= carry_d;
                    sum_sh_q <= sum_sh_d;
                    idx_q    <= idx_q + IDX_W'(1);
                    // Only the complete sum is published, never a partial one
                    if (idx_q == LAST_IDX) begin
                        resultado_q <= sum_sh_d;
                        cout_q      <= carry_d;
                        done_q      <= 1'b1;
                        state_q     <= FIN;
                    end
                end
                FIN: begin
                    // A start seen here is dropped, not queued
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign Resultado = resultado_q;
    assign Cout      = cout_q;

    // Wider results show only their low nibble; narrower ones are zero-extended
    assign nibble = 4'(resultado_q);

    // Hex decode of the registered low nibble, DE-board glyphs
    // NOTE: the default assignment before the case keeps this block free of inferred latches.
    always_comb begin
        salida7seg0 = SEG_ZERO;
        case (nibble)
            4'h0: salida7seg0 = 7'b1000000;
            4'h1: salida7seg0 = 7'b1111001;
            4'h2: salida7seg0 = 7'b0100100;
            4'h3: salida7seg0 = 7'b0110000;
            4'h4: salida7seg0 = 7'b0011001;
            4'h5: salida7seg0 = 7'b0010010;
            4'h6: salida7seg0 = 7'b0000010;
            4'h7: salida7seg0 = 7'b1111000;
            4'h8: salida7seg0 = 7'b0000000;
            4'h9: salida7seg0 = 7'b0010000;
            4'hA: salida7seg0 = 7'b0001000;
            4'hB: salida7seg0 = 7'b0000011;
            4'hC: salida7seg0 = 7'b1000110;
            4'hD: salida7seg0 = 7'b0100001;
            4'hE: salida7seg0 = 7'b0000110;
            4'hF: salida7seg0 = 7'b0001110;
            default: salida7seg0 = SEG_ZERO;
        endcase
    end

    // Carry digit: "1" or "0"
    always_comb begin
        salida7seg1 = cout_q ? SEG_ONE : SEG_ZERO;
    end

endmodule

// File: tb/tb_sumador_serial.sv
// Directed self-checking bench for sumador_serial (WIDTH=4).
// Outputs are sampled 1 time unit after each rising edge.
module tb_sumador_serial;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] Ent1;
    logic [WIDTH-1:0] Ent2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Resultado;
    logic             Cout;
    logic [6:0]       salida7seg0;
    logic [6:0]       salida7seg1;

    int checks = 0;
    int errors = 0;

    sumador_serial #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .Ent1        (Ent1),
        .Ent2        (Ent2),
        .busy        (busy),
        .done        (done),
        .Resultado   (Resultado),
        .Cout        (Cout),
        .salida7seg0 (salida7seg0),
        .salida7seg1 (salida7seg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written glyph table, active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation: start pulse, bounded wait for done, result and handshake checks
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input string tag);
        logic [4:0] exp;
        int         lat;
        int         dones;
        exp   = {1'b0, a} + {1'b0, b};
        Ent1  = a;
        Ent2  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "/busy_on"}, 32'(busy), 32'd1);
        lat   = 0;
        dones = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "/latency"}, 32'(lat), 32'(WIDTH));
        if (done) dones++;
        chk({tag, "/res"},  32'(Resultado),   32'(exp[3:0]));
        chk({tag, "/cout"}, 32'(Cout),        32'(exp[4]));
        chk({tag, "/seg0"}, 32'(salida7seg0), 32'(glyph(exp[3:0])));
        chk({tag, "/seg1"}, 32'(salida7seg1), 32'(exp[4] ? 7'b1111001 : 7'b1000000));
        tick();
        if (done) dones++;
        chk({tag, "/busy_off"}, 32'(busy), 32'd0);
        chk({tag, "/one_done"}, 32'(dones), 32'd1);
    endtask

    // Global time limit so the run can never hang
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "time limit");
    end

    initial begin
        int n_done;
        rst_n = 1'b0;
        start = 1'b0;
        Ent1  = '0;
        Ent2  = '0;
        #12;

        // Reset state
        chk("rst/busy", 32'(busy), 32'd0);
        chk("rst/done", 32'(done), 32'd0);
        chk("rst/res",  32'(Resultado), 32'd0);
        chk("rst/cout", 32'(Cout), 32'd0);
        chk("rst/seg0", 32'(salida7seg0), 32'(7'b1000000));
        chk("rst/seg1", 32'(salida7seg1), 32'(7'b1000000));
        rst_n = 1'b1;
        tick();

        // 1. 5+3: cycle-by-cycle timing, no partial sums visible
        Ent1  = 4'd5;
        Ent2  = 4'd3;
        start = 1'b1;
        tick();                                   // E0
        start = 1'b0;
        chk("t1/busy_e0", 32'(busy), 32'd1);
        chk("t1/done_e0", 32'(done), 32'd0);
        for (int i = 1; i < WIDTH; i++) begin     // E0+1 .. E0+3
            tick();
            chk($sformatf("t1/busy_e%0d", i), 32'(busy), 32'd1);
            chk($sformatf("t1/done_e%0d", i), 32'(done), 32'd0);
            chk($sformatf("t1/res_e%0d", i),  32'(Resultado), 32'd0);
        end
        tick();                                   // E0+4
        chk("t1/done",  32'(done), 32'd1);
        chk("t1/busy",  32'(busy), 32'd1);
        chk("t1/res",   32'(Resultado), 32'd8);
        chk("t1/cout",  32'(Cout), 32'd0);
        chk("t1/seg0",  32'(salida7seg0), 32'(7'b0000000));
        chk("t1/seg1",  32'(salida7seg1), 32'(7'b1000000));
        tick();                                   // E0+5
        chk("t1/done_off", 32'(done), 32'd0);
        chk("t1/busy_off", 32'(busy), 32'd0);
        chk("t1/res_hold", 32'(Resultado), 32'd8);

        // 2. 15+1 wraps to 0 with carry
        run_op(4'd15, 4'd1, "t2");
        chk("t2/seg1_one", 32'(salida7seg1), 32'(7'b1111001));

        // 3. 15+15 = 30 -> 14 with carry, shows "E"
        run_op(4'd15, 4'd15, "t3");
        chk("t3/seg0_E", 32'(salida7seg0), 32'(7'b0000110));

        // 4. start held high; Ent1 changes mid-op
        Ent1  = 4'd2;
        Ent2  = 4'd2;
        start = 1'b1;
        tick();                                   // E0 accepts 2+2
        Ent1 = 4'd9;
        for (int i = 0; i < WIDTH; i++) tick();   // E0+4
        chk("t4/done1", 32'(done), 32'd1);
        chk("t4/res1",  32'(Resultado), 32'd4);
        tick();                                   // E0+5: FIN -> IDLE, start ignored
        chk("t4/busy_gap", 32'(busy), 32'd0);
        tick();                                   // E0+6: second op accepted
        start = 1'b0;
        chk("t4/busy2", 32'(busy), 32'd1);
        chk("t4/res_hold", 32'(Resultado), 32'd4);
        for (int i = 0; i < WIDTH; i++) tick();
        chk("t4/done2", 32'(done), 32'd1);
        chk("t4/res2",  32'(Resultado), 32'd11);
        chk("t4/seg0_b", 32'(salida7seg0), 32'(7'b0000011));
        tick();

        // 5. reset in the 3rd SUMA cycle aborts the op with no done
        Ent1  = 4'd6;
        Ent2  = 4'd5;
        start = 1'b1;
        tick();                                   // E0
        start = 1'b0;
        tick();                                   // E0+1
        tick();                                   // E0+2
        rst_n = 1'b0;
        #1;
        chk("t5/busy", 32'(busy), 32'd0);
        chk("t5/done", 32'(done), 32'd0);
        chk("t5/res",  32'(Resultado), 32'd0);
        chk("t5/cout", 32'(Cout), 32'd0);
        #2;
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) n_done++;
        end
        chk("t5/no_done", 32'(n_done), 32'd0);
        chk("t5/idle", 32'(busy), 32'd0);
        run_op(4'd7, 4'd8, "t5b");
        chk("t5b/seg0_F", 32'(salida7seg0), 32'(7'b0001110));

        // 6. exhaustive sweep of operand pairs
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(4'(a), 4'(b), $sformatf("sweep_%0d_%0d", a, b));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
